// File: rtl/mag_cmp_seq.sv
// Sequential unsigned magnitude comparator: walks 2-bit slices MSB-first through
// one shared 2-bit compare stage, stopping at the first unequal slice.
module mag_cmp_seq #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic [CW-1:0]    cycles
);

  localparam int NSLICE = WIDTH / 2;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(NSLICE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cycles_q, cycles_d;
  logic             gt_q, gt_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;
  logic [1:0]       sa_s, sb_s;

  // Slice select depends only on registered operands and the slice index.
  assign sa_s = 2'(a_q >> {idx_q, 1'b0});
  assign sb_s = 2'(b_q >> {idx_q, 1'b0});

  // Next-state and datapath update for the IDLE/CMP/DONE sequence.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    idx_d    = idx_q;
    cycles_d = cycles_q;
    gt_d     = gt_q;
    eq_d     = eq_q;
    lt_d     = lt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          idx_d    = IDX_TOP;
          cycles_d = '0;
          state_d  = S_CMP;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_CMP: begin
        cycles_d = cycles_q + CW'(1);
        if (sa_s > sb_s) begin
          {gt_d, eq_d, lt_d} = 3'b100;
          state_d            = S_DONE;
        end else if (sa_s < sb_s) begin
          {gt_d, eq_d, lt_d} = 3'b001;
          state_d            = S_DONE;
        end else if (idx_q == '0) begin
          {gt_d, eq_d, lt_d} = 3'b010;
          state_d            = S_DONE;
        end else begin
          idx_d              = idx_q - IW'(1);
          state_d            = S_CMP;
        end
      end
      S_DONE: begin
        // Cycle count survives the handshake; only the flags are cleared.
        if (out_ready) begin
          {gt_d, eq_d, lt_d} = 3'b000;
          state_d            = S_IDLE;
        end else begin
          state_d            = S_DONE;
        end
      end
      default: begin
        {gt_d, eq_d, lt_d} = 3'b000;
        state_d            = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      idx_q    <= IDX_TOP;
      cycles_q <= '0;
      gt_q     <= 1'b0;
      eq_q     <= 1'b0;
      lt_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      idx_q    <= idx_d;
      cycles_q <= cycles_d;
      gt_q     <= gt_d;
      eq_q     <= eq_d;
      lt_q     <= lt_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign gt        = gt_q;
  assign eq        = eq_q;
  assign lt        = lt_q;
  assign cycles    = cycles_q;

endmodule

// File: tb/tb_mag_cmp_seq.sv
// Scoreboard bench for mag_cmp_seq: the driver queues expected results, a
// negedge monitor pops and compares on every result handshake.
module tb_mag_cmp_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       gt, eq, lt;
  logic [3:0] cycles;

  typedef struct packed {
    logic       gt;
    logic       eq;
    logic       lt;
    logic [3:0] cyc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  mag_cmp_seq #(.WIDTH(8), .CW(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .gt(gt), .eq(eq), .lt(lt), .cycles(cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pop one expectation per result handshake; check flag encoding.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) chk("onehot", 32'($countones({gt, eq, lt})), 32'd1);
      else           chk("flags_idle", {29'd0, gt, eq, lt}, 32'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("result_flags", {29'd0, gt, eq, lt}, {29'd0, e.gt, e.eq, e.lt});
          chk("result_cycles", {28'd0, cycles}, {28'd0, e.cyc});
        end
      end
    end
  end

  // Issue one operand pair, check latency; result checking is left to the monitor.
  task automatic run(input logic [7:0] av, input logic [7:0] bv,
                     input logic [2:0] fl, input logic [3:0] cyc);
    int n;
    int guard;
    exp_t e;
    guard = 0;
    @(posedge clk); #2;
    while (!in_ready && guard < 20) begin
      @(posedge clk); #2;
      guard++;
    end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    e.gt = fl[2]; e.eq = fl[1]; e.lt = fl[0]; e.cyc = cyc;
    exp_q.push_back(e);
    in_valid = 1'b1; a = av; b = bv;
    @(posedge clk); #2;
    in_valid = 1'b0;
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (out_valid) break;
    end
    chk("latency", 32'(n), {28'd0, cyc});
  endtask

  initial begin
    int k;
    logic [1:0] ah, bh;
    logic [2:0] fl;
    logic [3:0] cy;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_flags", {29'd0, gt, eq, lt}, 32'd0);
    chk("rst_cycles", {28'd0, cycles}, 32'd0);
    #1 rst_n = 1'b1;

    run(8'hA5, 8'h35, 3'b100, 4'd1);
    run(8'h5A, 8'h5A, 3'b010, 4'd4);
    run(8'h12, 8'h13, 3'b001, 4'd4);

    // Back-pressure: result held while out_ready is low, new pulse ignored.
    @(posedge clk); #2 out_ready = 1'b0;
    run(8'hC0, 8'h80, 3'b100, 4'd1);
    for (int j = 0; j < 3; j++) begin
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_gt", {31'd0, gt}, 32'd1);
      chk("bp_cycles", {28'd0, cycles}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      if (j == 0) begin
        #1 in_valid = 1'b1; a = 8'h00; b = 8'h00;
      end
      @(posedge clk); #1;
    end
    #1 in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_ret_in_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_ret_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_ret_cycles", {28'd0, cycles}, 32'd1);
    @(posedge clk); #1;
    chk("bp_not_accepted", {31'd0, in_ready}, 32'd1);

    // Reset during CMP discards the operation.
    #1 in_valid = 1'b1; a = 8'hFF; b = 8'hFF;
    @(posedge clk); #2 in_valid = 1'b0;
    @(posedge clk); #2 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_flags", {29'd0, gt, eq, lt}, 32'd0);
    chk("mid_rst_cycles", {28'd0, cycles}, 32'd0);
    #1 rst_n = 1'b1;
    run(8'h01, 8'h02, 3'b001, 4'd4);

    // Sweep all MSB-slice pairs over an identical low part.
    for (k = 0; k < 16; k++) begin
      ah = 2'(k >> 2);
      bh = 2'(k);
      if (ah > bh)      begin fl = 3'b100; cy = 4'd1; end
      else if (ah < bh) begin fl = 3'b001; cy = 4'd1; end
      else              begin fl = 3'b010; cy = 4'd4; end
      run({ah, 6'h15}, {bh, 6'h15}, fl, cy);
    end

    repeat (4) @(posedge clk);
    #1 chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mag_cmp_seq.md
Name: mag_cmp_seq

Overview:
- Sequential controller that compares two WIDTH-bit unsigned operands by stepping one 2-bit slice per cycle through a shared 2-bit magnitude-compare stage, MSB slice first.
- Terminates early on the first unequal slice.
- Valid/ready handshake on both input and result sides.
- Sits between operand producers and consumers wherever a wide compare is needed without a wide combinational comparator.

Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 2; NSLICE = WIDTH/2.
- CW, 4, width of cycle-count output; must satisfy 2^CW > NSLICE.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- gt  output  1  A > B.
- eq  output  1  A == B.
- lt  output  1  A < B.
- cycles  output  CW  number of slices examined for this result (1..NSLICE).

Behaviour:
- Reset (rst_n=0 at rising clk): state=IDLE, in_ready=1, out_valid=0, gt=eq=lt=0, cycles=0, slice index=NSLICE-1, operand registers cleared. Reset wins over every other event, including mid-CMP or mid-DONE; any pending result is discarded.
- States: IDLE, CMP, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready at an edge: register a and b, idx=NSLICE-1, cycles=0, go to CMP.
- CMP:
  - in_ready=0, out_valid=0. in_valid is ignored and a/b are not resampled.
  - Each edge: compare sa=A[2*idx+1:2*idx] against sb=B[2*idx+1:2*idx] as 2-bit unsigned values; cycles increments by 1.
  - If sa>sb: gt=1, eq=0, lt=0, go to DONE.
  - If sa<sb: lt=1, gt=0, eq=0, go to DONE.
  - If sa==sb and idx==0: eq=1, gt=0, lt=0, go to DONE.
  - If sa==sb and idx>0: idx decrements, stay in CMP.
- DONE:
  - out_valid=1, in_ready=0.
  - gt/eq/lt/cycles are held stable until out_valid&&out_ready at an edge.
  - On that handshake: go to IDLE, out_valid=0, flags cleared to 0, cycles retained.
- Exactly one of gt/eq/lt is 1 whenever out_valid=1; all three are 0 when out_valid=0.
- Latency: if the accept edge is T0, out_valid rises after edge T0+k, where k = number of slices examined (1 <= k <= NSLICE). cycles=k.
- Throughput: no accept in the same cycle as a result handshake. The next accept is possible the edge after returning to IDLE. Minimum period is k+2 cycles.
- Output back-pressure: out_ready low holds DONE indefinitely; no operand is lost because in_ready=0.
- out_ready high while not in DONE has no effect.
- Only idx and the registered operands drive the slice select; no combinational path from a/b to gt/eq/lt.
- NSLICE=1 (WIDTH=2): the single compare always terminates, so cycles=1.

Test Plan (WIDTH=8, out_ready=1 unless stated):
- Early gt: a=8'hA5, b=8'h35 accepted at T0 -> MSB slice 2'b10 vs 2'b00; out_valid after T0+1, gt=1, eq=0, lt=0, cycles=1.
- Full-depth equal: a=b=8'h5A -> four equal slices; out_valid after T0+4, eq=1, cycles=4.
- Late lt: a=8'h12, b=8'h13 -> slices 0,1,0 equal, last slice 2'b10 vs 2'b11; lt=1, cycles=4.
- Back-pressure: a=8'hC0, b=8'h80, out_ready=0 for 3 cycles after out_valid -> gt=1, cycles=1 held constant; in_ready=0 throughout. A new in_valid pulse (a=b=8'h00) during this window is not accepted. After out_ready=1, state returns to IDLE with in_ready=1.
- Reset mid-operation: a=b=8'hFF accepted, rst_n=0 at second CMP edge -> next cycle state IDLE, out_valid=0, flags=0, cycles=0, in_ready=1. A subsequent a=8'h01, b=8'h02 yields lt=1, cycles=4.
- Exhaustive slice check: sweep all 16 (a[7:6], b[7:6]) pairs with a[5:0]=b[5:0]=6'h15 -> unequal pairs give cycles=1 with correct gt/lt; equal pairs give eq=1, cycles=4.
